alu_operand_sequencer: RTL
==========================

Name: alu_operand_sequencer

Overview:
- Multi-cycle controller that sequences the ALU operand registers for one arithmetic request at a time.
- Drives the B-input register select strobes: data bus, inverted data bus, address-low.
- Drives the A-input select, the ALU operation code and the ALU carry-in.
- Detects page crossing on indexed address adds and issues a high-byte increment pass.
- Sits between the instruction decoder (requester) and the ALU input registers / ALU core.

Parameters:
- EXEC_CYCLES, 1, cycles the ALU strobe is held per pass (1..4); illegal values behave as 1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- req_VALID  input  1  request valid
- req_READY  output  1  sequencer can accept a request
- req_OP  input  3  0=ADD 1=SUB 2=CMP 3=IDX 4=INC; 5-7 illegal
- req_CARRY_IN  input  1  processor carry flag for ADD/SUB
- aluCarry_IN  input  1  ALU carry out, valid during EXEC
- abort_IN  input  1  cancel the in-flight request
- done_ACK  input  1  requester consumes the result
- bDataBus_EN  output  1  B register loads the data bus
- bDataBusInvert_EN  output  1  B register loads the inverted data bus
- bAddressLow_EN  output  1  B register loads address-low
- aSysBus_EN  output  1  A register loads the system bus
- aZero_EN  output  1  A register loads 0x00
- aluOp_OUT  output  2  0=SUM; other codes reserved (driven 0)
- aluCarry_OUT  output  1  ALU carry-in
- aluStrobe_OUT  output  1  ALU evaluate
- pageCross_OUT  output  1  fix-up pass was taken for the current result
- done_VALID  output  1  result ready
- error_OUT  output  1  one-cycle pulse on an illegal op
- busy_OUT  output  1  state is not IDLE

Behaviour:
- Reset values: every output is 0, except req_READY=1. State is IDLE.
- Handshake: a request is accepted on the clk edge where req_VALID and req_READY are both 1. req_READY=1 only in IDLE.
- States: IDLE -> LOAD -> EXEC -> (FIX_LOAD -> FIX_EXEC) -> DONE -> IDLE.
- LOAD (1 cycle): exactly one B enable is asserted, plus one A select. aluOp_OUT=0 and aluCarry_OUT are driven.
  - ADD: bDataBus_EN, aSysBus_EN, carry=req_CARRY_IN
  - SUB: bDataBusInvert_EN, aSysBus_EN, carry=req_CARRY_IN
  - CMP: bDataBusInvert_EN, aSysBus_EN, carry=1
  - IDX: bAddressLow_EN, aSysBus_EN, carry=0
  - INC: bDataBus_EN, aZero_EN, carry=1
- The op and carry are latched at acceptance. Later changes on the req_* inputs have no effect.
- EXEC: aluStrobe_OUT=1 and aluCarry_OUT is held for EXEC_CYCLES cycles, counted by a 2-bit counter. All B enables and A selects are 0.
- On the last EXEC cycle, aluCarry_IN is sampled:
  - IDX with carry=1: go to FIX_LOAD and set pageCross_OUT=1.
  - Otherwise: go to DONE.
- FIX_LOAD (1 cycle): bDataBus_EN (high byte), aZero_EN, carry=1.
- FIX_EXEC: same timing as EXEC. No further fix-up is possible; the next state is always DONE.
- DONE: done_VALID=1 and holds until done_ACK. The state goes to IDLE on the following edge.
  - pageCross_OUT is cleared on the transition out of DONE.
  - done_ACK outside DONE is ignored.
- Latency, acceptance edge to done_VALID:
  - 1+EXEC_CYCLES+1 cycles without fix-up.
  - 2*(1+EXEC_CYCLES)+1 cycles with fix-up.
- Illegal op (5-7): the request is accepted (the handshake completes). error_OUT pulses for the next cycle and the state stays IDLE. No enables are asserted.
- abort_IN in any non-IDLE state: next state is IDLE, and all outputs return to their reset values on that edge.
  - abort beats done_ACK when both are asserted.
  - abort in IDLE is ignored; a simultaneous valid request is still accepted.
- New request while in DONE: it waits, since req_READY=0. Earliest acceptance is the cycle after done_ACK.
- rst mid-operation: all outputs take their reset values on that edge, regardless of state or counter.
- Invariant: at most one of the three B enables is asserted in any cycle.
- Invariant: at most one of the two A selects is asserted in any cycle.

Test Plan:
- ADD, req_CARRY_IN=1, EXEC_CYCLES=1, accept at cycle 0 -> cycle 1: bDataBus_EN=1, aSysBus_EN=1, aluCarry_OUT=1; cycle 2: aluStrobe_OUT=1; cycle 3: done_VALID=1, held until done_ACK; req_READY=1 the cycle after the ack.
- SUB with req_CARRY_IN=0, then CMP with req_CARRY_IN=0 -> SUB: bDataBusInvert_EN=1, carry=0; CMP: bDataBusInvert_EN=1, carry=1.
- IDX with aluCarry_IN=1 during EXEC, EXEC_CYCLES=2 -> LOAD asserts bAddressLow_EN; strobe for 2 cycles; FIX_LOAD asserts bDataBus_EN, aZero_EN, carry=1; strobe for 2 more cycles; done_VALID at cycle 7 with pageCross_OUT=1. Repeat with aluCarry_IN=0 -> done_VALID at cycle 4, pageCross_OUT=0.
- req_OP=6 -> accepted, error_OUT=1 for exactly one cycle, no enables asserted, busy_OUT stays 0; a following ADD request is accepted the next cycle.
- abort_IN during FIX_EXEC with done_ACK also high -> IDLE next edge, done_VALID never asserted, pageCross_OUT=0, req_READY=1.
- rst asserted during EXEC (and separately during DONE) -> all outputs 0 and req_READY=1 after that edge; across a randomized run of 1000 requests, at most one B enable is ever high in any cycle.

Source files
------------

// File: rtl/alu_operand_sequencer.sv
// ALU operand sequencer: walks one arithmetic request through operand load,
// ALU evaluate and an optional high-byte fix-up pass for indexed addressing.
// All outputs are registered and computed from the state being entered.
module alu_operand_sequencer #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_VALID,
  output logic       req_READY,
  input  logic [2:0] req_OP,
  input  logic       req_CARRY_IN,
  input  logic       aluCarry_IN,
  input  logic       abort_IN,
  input  logic       done_ACK,
  output logic       bDataBus_EN,
  output logic       bDataBusInvert_EN,
  output logic       bAddressLow_EN,
  output logic       aSysBus_EN,
  output logic       aZero_EN,
  output logic [1:0] aluOp_OUT,
  output logic       aluCarry_OUT,
  output logic       aluStrobe_OUT,
  output logic       pageCross_OUT,
  output logic       done_VALID,
  output logic       error_OUT,
  output logic       busy_OUT
);

  // Out-of-range strobe lengths collapse to a single cycle.
  localparam int         LAST_I   = ((EXEC_CYCLES >= 1) && (EXEC_CYCLES <= 4)) ? (EXEC_CYCLES - 1) : 0;
  localparam logic [1:0] LAST_CNT = LAST_I[1:0];

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_CMP = 3'd2;
  localparam logic [2:0] OP_IDX = 3'd3;
  localparam logic [2:0] OP_INC = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_EXEC     = 3'd2,
    S_FIX_LOAD = 3'd3,
    S_FIX_EXEC = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t     state_r;
  logic [1:0] cnt_r;
  logic       idx_r;
  logic       carry_r;

  // Operand-load select pattern {bDataBus, bDataBusInvert, bAddressLow, aSysBus, aZero}.
  function automatic logic [4:0] load_sel(input logic [2:0] op);
    case (op)
      OP_ADD:  load_sel = 5'b10010;
      OP_SUB:  load_sel = 5'b01010;
      OP_CMP:  load_sel = 5'b01010;
      OP_IDX:  load_sel = 5'b00110;
      OP_INC:  load_sel = 5'b10001;
      default: load_sel = 5'b00000;
    endcase
  endfunction

  // ALU carry-in for the first pass: CMP/INC force 1, IDX forces 0.
  function automatic logic load_carry(input logic [2:0] op, input logic cin);
    case (op)
      OP_ADD:  load_carry = cin;
      OP_SUB:  load_carry = cin;
      OP_CMP:  load_carry = 1'b1;
      OP_IDX:  load_carry = 1'b0;
      OP_INC:  load_carry = 1'b1;
      default: load_carry = 1'b0;
    endcase
  endfunction

  // Sequencer state machine with registered outputs for the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r           <= S_IDLE;
      cnt_r             <= 2'd0;
      idx_r             <= 1'b0;
      carry_r           <= 1'b0;
      req_READY         <= 1'b1;
      bDataBus_EN       <= 1'b0;
      bDataBusInvert_EN <= 1'b0;
      bAddressLow_EN    <= 1'b0;
      aSysBus_EN        <= 1'b0;
      aZero_EN          <= 1'b0;
      aluOp_OUT         <= 2'd0;
      aluCarry_OUT      <= 1'b0;
      aluStrobe_OUT     <= 1'b0;
      pageCross_OUT     <= 1'b0;
      done_VALID        <= 1'b0;
      error_OUT         <= 1'b0;
      busy_OUT          <= 1'b0;
    end else if (abort_IN && (state_r != S_IDLE)) begin
      // Abort takes priority over everything, including done_ACK.
      state_r           <= S_IDLE;
      cnt_r             <= 2'd0;
      idx_r             <= 1'b0;
      carry_r           <= 1'b0;
      req_READY         <= 1'b1;
      bDataBus_EN       <= 1'b0;
      bDataBusInvert_EN <= 1'b0;
      bAddressLow_EN    <= 1'b0;
      aSysBus_EN        <= 1'b0;
      aZero_EN          <= 1'b0;
      aluOp_OUT         <= 2'd0;
      aluCarry_OUT      <= 1'b0;
      aluStrobe_OUT     <= 1'b0;
      pageCross_OUT     <= 1'b0;
      done_VALID        <= 1'b0;
      error_OUT         <= 1'b0;
      busy_OUT          <= 1'b0;
    end else begin
      // Per-cycle strobes default low; pageCross_OUT holds until DONE is left.
      req_READY         <= 1'b0;
      bDataBus_EN       <= 1'b0;
      bDataBusInvert_EN <= 1'b0;
      bAddressLow_EN    <= 1'b0;
      aSysBus_EN        <= 1'b0;
      aZero_EN          <= 1'b0;
      aluOp_OUT         <= 2'd0;
      aluCarry_OUT      <= 1'b0;
      aluStrobe_OUT     <= 1'b0;
      done_VALID        <= 1'b0;
      error_OUT         <= 1'b0;
      busy_OUT          <= 1'b1;
      case (state_r)
        S_IDLE: begin
          if (req_VALID && req_READY && (req_OP <= OP_INC)) begin
            state_r      <= S_LOAD;
            idx_r        <= (req_OP == OP_IDX);
            carry_r      <= load_carry(req_OP, req_CARRY_IN);
            aluCarry_OUT <= load_carry(req_OP, req_CARRY_IN);
            {bDataBus_EN, bDataBusInvert_EN, bAddressLow_EN, aSysBus_EN, aZero_EN} <= load_sel(req_OP);
          end else if (req_VALID && req_READY) begin
            // Illegal op: complete the handshake, flag it, stay idle.
            error_OUT <= 1'b1;
            req_READY <= 1'b1;
            busy_OUT  <= 1'b0;
          end else begin
            req_READY <= 1'b1;
            busy_OUT  <= 1'b0;
          end
        end
        S_LOAD: begin
          state_r       <= S_EXEC;
          cnt_r         <= 2'd0;
          aluStrobe_OUT <= 1'b1;
          aluCarry_OUT  <= carry_r;
        end
        S_EXEC: begin
          if ((cnt_r == LAST_CNT) && idx_r && aluCarry_IN) begin
            // Low-byte add carried out: increment the high byte.
            state_r       <= S_FIX_LOAD;
            pageCross_OUT <= 1'b1;
            bDataBus_EN   <= 1'b1;
            aZero_EN      <= 1'b1;
            aluCarry_OUT  <= 1'b1;
          end else if (cnt_r == LAST_CNT) begin
            state_r    <= S_DONE;
            done_VALID <= 1'b1;
          end else begin
            cnt_r         <= cnt_r + 2'd1;
            aluStrobe_OUT <= 1'b1;
            aluCarry_OUT  <= carry_r;
          end
        end
        S_FIX_LOAD: begin
          state_r       <= S_FIX_EXEC;
          cnt_r         <= 2'd0;
          aluStrobe_OUT <= 1'b1;
          aluCarry_OUT  <= 1'b1;
        end
        S_FIX_EXEC: begin
          if (cnt_r == LAST_CNT) begin
            state_r    <= S_DONE;
            done_VALID <= 1'b1;
          end else begin
            cnt_r         <= cnt_r + 2'd1;
            aluStrobe_OUT <= 1'b1;
            aluCarry_OUT  <= 1'b1;
          end
        end
        S_DONE: begin
          if (done_ACK) begin
            state_r       <= S_IDLE;
            pageCross_OUT <= 1'b0;
            req_READY     <= 1'b1;
            busy_OUT      <= 1'b0;
          end else begin
            done_VALID <= 1'b1;
          end
        end
        default: begin
          state_r       <= S_IDLE;
          pageCross_OUT <= 1'b0;
          req_READY     <= 1'b1;
          busy_OUT      <= 1'b0;
        end
      endcase
    end
  end

endmodule
